// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter. Display fetches take priority over queued CPU
// writes. CPU writes are range-checked and then queued in a small FIFO.
// Read data comes back through a two-stage valid pipeline.
module vga_fb_arbiter #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk27,
  input  logic        rst27,
  input  logic        disp_req,
  input  logic [9:0]  disp_x,
  input  logic [9:0]  disp_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        pix_valid,
  input  logic        cpu_wr_valid,
  output logic        cpu_wr_ready,
  input  logic [9:0]  cpu_wr_x,
  input  logic [9:0]  cpu_wr_y,
  input  logic [23:0] cpu_wr_rgb,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [23:0] mem_wdata,
  input  logic [23:0] mem_rdata,
  output logic [2:0]  fifo_level,
  output logic [7:0]  drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 19 + 24;

  // Linear word address. The default 640-wide line is computed as y*512 + y*128,
  // which needs only shifts and adds.
  function automatic logic [18:0] addr_calc(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] xe;
    logic [18:0] ye;
    xe = {9'd0, x};
    ye = {9'd0, y};
    if (H_ACT == 640) addr_calc = (ye << 9) + (ye << 7) + xe;
    else              addr_calc = 19'(ye * 19'(H_ACT)) + xe;
  endfunction

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [18:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [23:0]      mem_wdata_q, mem_wdata_d;
  logic             vld_p0_q, vld_p0_d;
  logic             vld_p1_q, vld_p1_d;
  logic             pix_valid_q, pix_valid_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic [7:0]       drop_q, drop_d;
  logic             accept, in_range, push, pop;
  logic [ENT_W-1:0] head;

  // Grant decision, FIFO bookkeeping and next values of the memory port.
  always_comb begin
    cpu_wr_ready = (cnt_q < CNT_W'(FIFO_DEPTH)) && !rst27;
    accept       = cpu_wr_valid && cpu_wr_ready;
    in_range     = ({22'd0, cpu_wr_x} < 32'(H_ACT)) && ({22'd0, cpu_wr_y} < 32'(V_ACT));
    push         = accept && in_range;
    pop          = !disp_req && (cnt_q != '0);
    head         = fifo_mem_q[rd_ptr_q];

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    drop_d      = (accept && !in_range) ? sat_inc8(drop_q) : drop_q;

    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (disp_req) begin
      mem_addr_d  = addr_calc(disp_x, disp_y);
    end else if (pop) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = head[ENT_W-1:24];
      mem_wdata_d = head[23:0];
    end

    vld_p0_d    = disp_req;
    vld_p1_d    = vld_p0_q;
    pix_valid_d = vld_p1_q;
    pix_rgb_d   = vld_p1_q ? mem_rdata : 24'd0;
  end

  // State and output registers, all cleared by reset.
  always_ff @(posedge clk27) begin
    if (rst27) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      drop_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_rgb_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      pix_valid_q <= pix_valid_d;
      pix_rgb_q   <= pix_rgb_d;
    end
  end

  // FIFO storage. Entries are only read while counted, so no reset is needed.
  always_ff @(posedge clk27) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {addr_calc(cpu_wr_x, cpu_wr_y), cpu_wr_rgb};
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_r      = pix_rgb_q[23:16];
  assign pix_g      = pix_rgb_q[15:8];
  assign pix_b      = pix_rgb_q[7:0];
  assign pix_valid  = pix_valid_q;
  assign fifo_level = 3'(cnt_q);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: table vectors plus sequences for reads, fill,
// drops, queue ordering and mid-operation reset.
module tb_vga_fb_arbiter;

  logic        clk27 = 1'b0;
  logic        rst27;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [9:0]  cpu_wr_x, cpu_wr_y;
  logic [23:0] cpu_wr_rgb;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  always #5 clk27 = ~clk27;

  vga_fb_arbiter dut (
    .clk27(clk27), .rst27(rst27),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_x(cpu_wr_x), .cpu_wr_y(cpu_wr_y), .cpu_wr_rgb(cpu_wr_rgb),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  function automatic logic [23:0] fake_mem(input logic [18:0] a);
    if (a == 19'd307199) return 24'hAABBCC;
    return {5'd0, a} ^ 24'h5A5A5A;
  endfunction

  // Synchronous memory: data valid one cycle after the address.
  always @(posedge clk27) mem_rdata <= fake_mem(mem_addr);

  task automatic step();
    @(posedge clk27);
    #1;
    if (mem_we) we_cnt++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [18:0] ref_addr(input int x, input int y);
    return 19'(y * 640 + x);
  endfunction

  task automatic set_in(input logic dr, input int dx, input int dy,
                        input logic wv, input int wx, input int wy, input logic [23:0] rgb);
    disp_req = dr; disp_x = 10'(dx); disp_y = 10'(dy);
    cpu_wr_valid = wv; cpu_wr_x = 10'(wx); cpu_wr_y = 10'(wy); cpu_wr_rgb = rgb;
  endtask

  // Reference queue model of the write FIFO.
  logic [42:0] ref_q[$];

  task automatic model_step(input logic dr, input logic wv, input int wx, input int wy,
                            input logic [23:0] rgb);
    bit rdy, pop_e, push_e;
    logic [42:0] e;
    set_in(dr, 0, 0, wv, wx, wy, rgb);
    rdy    = ref_q.size() < 4;
    pop_e  = !dr && ref_q.size() > 0;
    push_e = wv && rdy;
    chk("mdl_ready", cpu_wr_ready, rdy);
    step();
    chk("mdl_we", mem_we, pop_e);
    if (pop_e) begin
      e = ref_q.pop_front();
      chk("mdl_addr", mem_addr, e[42:24]);
      chk("mdl_wdata", mem_wdata, e[23:0]);
    end
    if (push_e) ref_q.push_back({ref_addr(wx, wy), rgb});
    chk("mdl_level", fifo_level, ref_q.size());
  endtask

  typedef struct {
    logic dr; int dx; int dy;
    logic wv; int wx; int wy; logic [23:0] rgb;
    logic e_rdy; logic e_we; logic [18:0] e_addr; logic [23:0] e_wd;
    logic [2:0] e_lvl; logic [7:0] e_drop;
  } vec_t;

  vec_t vt[11];

  initial begin
    int wbase;
    vt[0]  = '{1'b0, 0, 0,    1'b0, 0, 0,     24'h0,      1'b1, 1'b0, 19'd0,      24'h0,      3'd0, 8'd0};
    vt[1]  = '{1'b0, 0, 0,    1'b1, 5, 2,     24'h123456, 1'b1, 1'b0, 19'd0,      24'h0,      3'd1, 8'd0};
    vt[2]  = '{1'b0, 0, 0,    1'b0, 0, 0,     24'h0,      1'b1, 1'b1, 19'd1285,   24'h123456, 3'd0, 8'd0};
    vt[3]  = '{1'b0, 0, 0,    1'b0, 0, 0,     24'h0,      1'b1, 1'b0, 19'd1285,   24'h123456, 3'd0, 8'd0};
    vt[4]  = '{1'b1, 10, 1,   1'b0, 0, 0,     24'h0,      1'b1, 1'b0, 19'd650,    24'h123456, 3'd0, 8'd0};
    vt[5]  = '{1'b1, 0, 0,    1'b1, 3, 3,     24'hABCDEF, 1'b1, 1'b0, 19'd0,      24'h123456, 3'd1, 8'd0};
    vt[6]  = '{1'b0, 0, 0,    1'b1, 1, 0,     24'h000111, 1'b1, 1'b1, 19'd1923,   24'hABCDEF, 3'd1, 8'd0};
    vt[7]  = '{1'b0, 0, 0,    1'b0, 0, 0,     24'h0,      1'b1, 1'b1, 19'd1,      24'h000111, 3'd0, 8'd0};
    vt[8]  = '{1'b0, 0, 0,    1'b1, 640, 0,   24'h777777, 1'b1, 1'b0, 19'd1,      24'h000111, 3'd0, 8'd1};
    vt[9]  = '{1'b0, 0, 0,    1'b1, 639, 479, 24'hFFFFFF, 1'b1, 1'b0, 19'd1,      24'h000111, 3'd1, 8'd1};
    vt[10] = '{1'b0, 0, 0,    1'b0, 0, 0,     24'h0,      1'b1, 1'b1, 19'd307199, 24'hFFFFFF, 3'd0, 8'd1};

    // Reset state
    rst27 = 1'b1;
    set_in(1'b0, 0, 0, 1'b0, 0, 0, 24'h0);
    step(); step();
    chk("rst_ready", cpu_wr_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 19'd0);
    chk("rst_wdata", mem_wdata, 24'd0);
    chk("rst_pix", {pix_valid, pix_r, pix_g, pix_b}, 25'd0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    rst27 = 1'b0;
    #1;
    chk("rel_ready", cpu_wr_ready, 1'b1);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      set_in(vt[i].dr, vt[i].dx, vt[i].dy, vt[i].wv, vt[i].wx, vt[i].wy, vt[i].rgb);
      #1;
      chk($sformatf("v%0d_ready", i), cpu_wr_ready, vt[i].e_rdy);
      step();
      chk($sformatf("v%0d_we", i), mem_we, vt[i].e_we);
      chk($sformatf("v%0d_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, vt[i].e_wd);
      chk($sformatf("v%0d_level", i), fifo_level, vt[i].e_lvl);
      chk($sformatf("v%0d_drop", i), drop_cnt, vt[i].e_drop);
    end

    // Single display read at the last pixel
    set_in(1'b1, 639, 479, 1'b0, 0, 0, 24'h0);
    step();
    chk("rd_addr", mem_addr, 19'd307199);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_v_n", pix_valid, 1'b0);
    disp_req = 1'b0;
    step();
    chk("rd_v_n1", pix_valid, 1'b0);
    step();
    chk("rd_v_n2", pix_valid, 1'b1);
    chk("rd_pix", {pix_r, pix_g, pix_b}, 24'hAABBCC);
    step();
    chk("rd_v_n3", {pix_valid, pix_r, pix_g, pix_b}, 25'd0);

    // Back-to-back reads
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, i, 0, 1'b0, 0, 0, 24'h0);
      step();
      if (i == 2) begin
        chk("b2b_v0", pix_valid, 1'b1);
        chk("b2b_p0", {pix_r, pix_g, pix_b}, fake_mem(ref_addr(0, 0)));
      end
    end
    disp_req = 1'b0;
    for (int i = 1; i < 3; i++) begin
      step();
      chk($sformatf("b2b_v%0d", i), pix_valid, 1'b1);
      chk($sformatf("b2b_p%0d", i), {pix_r, pix_g, pix_b}, fake_mem(ref_addr(i, 0)));
    end
    step();
    chk("b2b_end", pix_valid, 1'b0);

    // Fill under a continuous display request
    wbase = we_cnt;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 0, 0, 1'b1, i, 1, 24'h100000 + 24'(i));
      #1;
      chk($sformatf("fill_rdy%0d", i), cpu_wr_ready, i < 4);
      step();
    end
    cpu_wr_valid = 1'b0;
    step(); step();
    chk("fill_level", fifo_level, 3'd4);
    chk("fill_ready", cpu_wr_ready, 1'b0);
    chk("fill_starved", we_cnt - wbase, 0);
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("drain_we%0d", i), mem_we, 1'b1);
      chk($sformatf("drain_addr%0d", i), mem_addr, ref_addr(i, 1));
      chk($sformatf("drain_wd%0d", i), mem_wdata, 24'h100000 + 24'(i));
      chk($sformatf("drain_lvl%0d", i), fifo_level, 3'(3 - i));
    end
    step();
    chk("drain_idle", mem_we, 1'b0);

    // Out-of-range writes
    wbase = we_cnt;
    set_in(1'b0, 0, 0, 1'b1, 640, 0, 24'h1);
    step();
    chk("oor_x_drop", drop_cnt, 8'd2);
    set_in(1'b0, 0, 0, 1'b1, 0, 480, 24'h2);
    step();
    chk("oor_y_drop", drop_cnt, 8'd3);
    for (int i = 0; i < 300; i++) begin
      set_in(1'b0, 0, 0, 1'b1, 700 + (i % 300), i % 1024, 24'h3);
      step();
    end
    cpu_wr_valid = 1'b0;
    step();
    chk("oor_sat", drop_cnt, 8'd255);
    chk("oor_level", fifo_level, 3'd0);
    chk("oor_no_we", we_cnt - wbase, 0);

    // Simultaneous push/pop and ordering against the reference queue
    model_step(1'b1, 1'b1, 10, 20, 24'hA00001);
    model_step(1'b1, 1'b1, 11, 21, 24'hA00002);
    chk("pp_level2", fifo_level, 3'd2);
    model_step(1'b0, 1'b1, 12, 22, 24'hA00003);
    chk("pp_same", fifo_level, 3'd2);
    model_step(1'b0, 1'b1, 13, 23, 24'hA00004);
    model_step(1'b1, 1'b1, 14, 24, 24'hA00005);
    model_step(1'b1, 1'b1, 15, 25, 24'hA00006);
    model_step(1'b1, 1'b1, 16, 26, 24'hA00007);
    model_step(1'b0, 1'b0, 0, 0, 24'h0);
    model_step(1'b0, 1'b1, 17, 27, 24'hA00008);
    model_step(1'b1, 1'b0, 0, 0, 24'h0);
    for (int i = 0; i < 6; i++) model_step(1'b0, 1'b0, 0, 0, 24'h0);
    chk("pp_empty", fifo_level, 3'd0);

    // Reset in the middle of queued writes and in-flight reads
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 0, 0, 1'b1, 50 + i, 5, 24'hC0 + 24'(i));
      step();
    end
    cpu_wr_valid = 1'b0;
    chk("mr_level3", fifo_level, 3'd3);
    rst27 = 1'b1;
    disp_req = 1'b0;
    #1;
    chk("mr_rdy_rst", cpu_wr_ready, 1'b0);
    step();
    chk("mr_level", fifo_level, 3'd0);
    chk("mr_we", mem_we, 1'b0);
    chk("mr_pix", pix_valid, 1'b0);
    chk("mr_drop", drop_cnt, 8'd0);
    rst27 = 1'b0;
    #1;
    chk("mr_rdy_rel", cpu_wr_ready, 1'b1);
    wbase = we_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("mr_pixv%0d", i), pix_valid, 1'b0);
    end
    chk("mr_no_we", we_cnt - wbase, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
